// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised XNOR-feedback Fibonacci LFSR with seed load,
// free-run / counted-burst modes, busy/done handshake and all-ones
// lockup detection with recovery to SEED.
// Optional macro LFSR_PERIOD_CHK_EN adds a period measurement
// (period_len / period_vld) against the value captured at reset or load.
module lfsr_gen #(
  parameter int               WIDTH = 10,
  parameter logic [WIDTH-1:0] TAPS  = 10'b1001000000,
  parameter logic [WIDTH-1:0] SEED  = 10'b0101010101,
  parameter int               CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic [WIDTH-1:0] q,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic             lockup
`ifdef LFSR_PERIOD_CHK_EN
  ,
  output logic [WIDTH-1:0] period_len,
  output logic             period_vld
`endif
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;

  logic             fb;
  logic             at_ones;
  logic             step;
  logic [WIDTH-1:0] q_shift;
  logic [WIDTH-1:0] q_step;

  // Next-state datapath: feedback, lockup recovery and step qualification.
  // In IDLE a start request blocks the step for that cycle; load blocks everything.
  always_comb begin
    fb      = ~^(q & TAPS);
    q_shift = {q[WIDTH-2:0], fb};
    at_ones = &q;
    q_step  = at_ones ? SEED : q_shift;
    step    = 1'b0;
    if (!load) begin
      if (state == IDLE) step = en && !start;
      else               step = en;
    end
  end

  assign out = q[WIDTH-1];

  // Control FSM, shift register and registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      q      <= SEED;
      count  <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      lockup <= 1'b0;
    end else begin
      valid <= step;
      done  <= 1'b0;
      if (load) begin
        q      <= seed_in;
        lockup <= 1'b0;
        state  <= IDLE;
        count  <= '0;
        busy   <= 1'b0;
      end else begin
        if (step) begin
          q <= q_step;
          if (at_ones) lockup <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (start) begin
              if (burst_len != '0) begin
                count <= burst_len;
                state <= BURST;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          BURST: begin
            if (en) begin
              count <= count - 1'b1;
              if (count == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef LFSR_PERIOD_CHK_EN
  logic [WIDTH-1:0] ref_q;
  logic [WIDTH-1:0] pcnt;

  // Period measurement: count steps until q returns to the captured reference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ref_q      <= SEED;
      pcnt       <= '0;
      period_len <= '0;
      period_vld <= 1'b0;
    end else begin
      period_vld <= 1'b0;
      if (load) begin
        ref_q <= seed_in;
        pcnt  <= '0;
      end else if (step && at_ones) begin
        pcnt <= '0;
      end else if (step) begin
        if (q_step == ref_q) begin
          period_len <= pcnt + 1'b1;
          period_vld <= 1'b1;
          pcnt       <= '0;
        end else begin
          pcnt <= pcnt + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: directed self-checking bench for lfsr_gen (default parameters).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lfsr_gen;

  localparam logic [9:0] SEED = 10'b0101010101;
  localparam logic [9:0] ONES = 10'b1111111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, load, start;
  logic [9:0]  seed_in;
  logic [15:0] burst_len;
  logic [9:0]  q;
  logic        out, valid, busy, done, lockup;
`ifdef LFSR_PERIOD_CHK_EN
  logic [9:0]  period_len;
  logic        period_vld;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (en),
    .load      (load),
    .seed_in   (seed_in),
    .start     (start),
    .burst_len (burst_len),
    .q         (q),
    .out       (out),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .lockup    (lockup)
`ifdef LFSR_PERIOD_CHK_EN
    ,
    .period_len(period_len),
    .period_vld(period_vld)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Reference step for taps 9 and 6: XNOR feedback, all-ones recovers to SEED.
  function automatic logic [9:0] nxt(input logic [9:0] s);
    if (s == ONES) return SEED;
    return {s[8:0], ~(s[9] ^ s[6])};
  endfunction

  logic [9:0] s;
  int         ones_seen, busy_cnt, valid_cnt, done_cnt, early_done;
  int         pv_seen;
  logic [9:0] plen;
  logic       pat [7];

  initial begin
    reset_n = 1'b0; en = 1'b0; load = 1'b0; start = 1'b0;
    seed_in = '0; burst_len = '0;
    pv_seen = 0; plen = '0;
    repeat (2) @(negedge clk);
    chk("rst_q", q, SEED);
    chk("rst_out", out, 1'b0);
    chk("rst_valid", valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_lockup", lockup, 1'b0);

    // 1. free-run full period
    reset_n = 1'b1; en = 1'b1;
    ones_seen = 0;
    for (int i = 1; i <= 1023; i++) begin
      @(negedge clk);
      if (i == 1) begin
        chk("fr_step1", q, 10'b1010101010);
        chk("fr_valid", valid, 1'b1);
        chk("fr_out", out, 1'b1);
      end
      if (i == 2) chk("fr_step2", q, 10'b0101010100);
      if (q == ONES) ones_seen++;
`ifdef LFSR_PERIOD_CHK_EN
      if (period_vld) begin pv_seen++; plen = period_len; end
`endif
    end
    chk("fr_period_q", q, SEED);
    chk("fr_no_ones", ones_seen, 0);
`ifdef LFSR_PERIOD_CHK_EN
    chk("per_vld", pv_seen, 1);
    chk("per_len", plen, 10'd1023);
`endif

    // 2. burst of 5 with en held high
    s = q;
    start = 1'b1; burst_len = 16'd5; en = 1'b1;
    busy_cnt = 0; valid_cnt = 0; done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      busy_cnt  += busy;
      valid_cnt += valid;
      done_cnt  += done;
      if (k == 0) begin
        chk("b5_nostep", q, s);
        start = 1'b0;
      end
      if (k == 5) begin
        chk("b5_done_at5", done, 1'b1);
        en = 1'b0;
      end
    end
    for (int k = 0; k < 5; k++) s = nxt(s);
    chk("b5_busy_cnt", busy_cnt, 5);
    chk("b5_valid_cnt", valid_cnt, 5);
    chk("b5_done_cnt", done_cnt, 1);
    chk("b5_q", q, s);
    chk("b5_idle", busy, 1'b0);

    // 3. burst of 4 with stalls
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    s = q;
    start = 1'b1; burst_len = 16'd4; en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k > 0 && pat[k-1]) s = nxt(s);
      chk($sformatf("b4_q%0d", k), q, s);
      chk($sformatf("b4_done%0d", k), done, (k == 7));
      chk($sformatf("b4_busy%0d", k), busy, (k < 7));
      if (k == 0) start = 1'b0;
      en = (k < 7) ? pat[k] : 1'b0;
    end

    // 4. lockup via load of all-ones, then recovery and clear
    load = 1'b1; seed_in = ONES;
    @(negedge clk);
    load = 1'b0;
    chk("lk_loaded", q, ONES);
    chk("lk_valid0", valid, 1'b0);
    chk("lk_flag0", lockup, 1'b0);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    chk("lk_recover", q, SEED);
    chk("lk_flag1", lockup, 1'b1);
    chk("lk_valid1", valid, 1'b1);
    @(negedge clk);
    chk("lk_sticky", lockup, 1'b1);
    load = 1'b1; seed_in = 10'b0000000001;
    @(negedge clk);
    load = 1'b0;
    chk("lk_clear", lockup, 1'b0);
    chk("lk_q1", q, 10'b0000000001);

    // load beats start
    load = 1'b1; start = 1'b1; burst_len = 16'd3; seed_in = 10'h155;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    chk("ls_q", q, 10'h155);
    chk("ls_busy", busy, 1'b0);
    @(negedge clk);
    chk("ls_done", done, 1'b0);
    chk("ls_busy2", busy, 1'b0);

    // 5. zero-length burst: no step, one done pulse
    s = q;
    start = 1'b1; burst_len = 16'd0; en = 1'b1;
    @(negedge clk);
    start = 1'b0; en = 1'b0;
    chk("z_q", q, s);
    chk("z_done", done, 1'b1);
    chk("z_busy", busy, 1'b0);
    chk("z_valid", valid, 1'b0);
    @(negedge clk);
    chk("z_done_once", done, 1'b0);

    // maximal burst length runs the full count without wrap
    s = q;
    start = 1'b1; burst_len = 16'hFFFF; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    early_done = 0;
    for (int k = 1; k <= 65535; k++) begin
      @(negedge clk);
      s = nxt(s);
      if (k < 65535 && (done || !busy)) early_done++;
    end
    en = 1'b0;
    chk("max_early", early_done, 0);
    chk("max_done", done, 1'b1);
    chk("max_busy", busy, 1'b0);
    chk("max_q", q, s);

    // reset mid-burst of 10 after 3 steps
    start = 1'b1; burst_len = 16'd10; en = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mr_busy_pre", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mr_q", q, SEED);
    chk("mr_busy", busy, 1'b0);
    chk("mr_valid", valid, 1'b0);
    en = 1'b0;
    @(negedge clk);
    chk("mr_done", done, 1'b0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("mr_done2", done, 1'b0);
    chk("mr_q2", q, SEED);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
